// File: rtl/usbeps_rx_framer.sv
// USB RX endpoint framer: turns RX RAM burst descriptors into a 16-byte header plus 32-bit payload dwords.
// Optional statistics counters are built only when USBEPS_RX_FRAMER_STAT_EN is defined.
module usbeps_rx_framer #(
  parameter int DATA_BITS         = 3,
  parameter int RX_TIMESTAMP_BITS = 48,
  parameter int RX_RAM_ADDR_WIDTH = 16,
  parameter int RX_SAMPLES_WIDTH  = 15,
  parameter int EP_DWORDS         = 128
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       rxs_burst_valid,
  output logic                                       rxs_burst_ready,
  input  logic [RX_TIMESTAMP_BITS+RX_SAMPLES_WIDTH+(RX_RAM_ADDR_WIDTH-DATA_BITS):0] rxs_burst_data,
  output logic                                       mem_arvalid,
  input  logic                                       mem_arready,
  output logic [RX_RAM_ADDR_WIDTH-DATA_BITS-1:0]     mem_araddr,
  input  logic                                       mem_rvalid,
  input  logic [63:0]                                mem_rdata,
  output logic                                       m_axis_endpoint_rx_valid,
  input  logic                                       m_axis_endpoint_rx_ready,
  output logic [31:0]                                m_axis_endpoint_rx_data,
  output logic [3:0]                                 m_axis_endpoint_rx_keep,
  output logic                                       m_axis_endpoint_rx_last,
  output logic [RX_RAM_ADDR_WIDTH-DATA_BITS-1:0]     rxs_rd_addr,
  output logic [31:0]                                stat
);

  localparam int AW  = RX_RAM_ADDR_WIDTH - DATA_BITS;
  localparam int SW  = RX_SAMPLES_WIDTH;
  localparam int TW  = RX_TIMESTAMP_BITS;
  localparam int RCW = SW + 1;
  localparam int EPW = $clog2(EP_DWORDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3, ST_DATA_L, ST_DATA_H
  } state_t;

  logic [AW-1:0] desc_start;
  logic [SW-1:0] desc_samples;
  logic [TW-1:0] desc_ts;
  logic          desc_ovr;
  assign {desc_ovr, desc_ts, desc_samples, desc_start} = rxs_burst_data;

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [EPW-1:0]  ep_cnt_q, ep_cnt_d;
  logic [TW-1:0]   ts_q, ts_d;
  logic [SW-1:0]   samples_q, samples_d;
  logic            ovr_q, ovr_d;
  logic [SW-1:0]   sent_cnt_q, sent_cnt_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]   ar_addr_q, ar_addr_d;
  logic [RCW-1:0]  req_cnt_q, req_cnt_d;
  logic [1:0]      outst_q, outst_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [63:0]     fifo_mem_q [2];
  logic [63:0]     fifo_mem_d [2];

  logic            desc_hs, out_hs, ar_hs, r_acc, pop, final_hs, last_word;
  logic            load, load_final;
  logic [31:0]     load_val;
  logic [63:0]     head;
  logic [RCW-1:0]  req_total;
  logic [2:0]      occupancy;

  assign rxs_burst_ready = !rst && (state_q == ST_IDLE) && !out_valid_q;
  assign desc_hs         = rxs_burst_valid && rxs_burst_ready;
  assign out_hs          = out_valid_q && m_axis_endpoint_rx_ready;
  assign head            = fifo_mem_q[rd_ptr_q];
  assign last_word       = (sent_cnt_q == samples_q);

  // Read credit: never more words in flight plus buffered than the FIFO holds.
  assign req_total   = {1'b0, samples_q} + RCW'(1);
  assign occupancy   = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign mem_arvalid = !rst && (state_q != ST_IDLE) && (req_cnt_q != req_total) && (occupancy < 3'd2);
  assign mem_araddr  = ar_addr_q;
  assign ar_hs       = mem_arvalid && mem_arready;
  assign r_acc       = mem_rvalid && (outst_q != 2'd0);

  assign m_axis_endpoint_rx_valid = out_valid_q;
  assign m_axis_endpoint_rx_data  = out_data_q;
  assign m_axis_endpoint_rx_keep  = 4'hF;
  assign m_axis_endpoint_rx_last  = out_last_q;
  assign rxs_rd_addr              = rd_addr_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    ep_cnt_d    = ep_cnt_q;
    ts_d        = ts_q;
    samples_d   = samples_q;
    ovr_d       = ovr_q;
    sent_cnt_d  = sent_cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_ptr_d    = rd_ptr_q;
    pop         = 1'b0;
    final_hs    = 1'b0;
    load        = 1'b0;
    load_final  = 1'b0;
    load_val    = '0;

    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      ep_cnt_d    = out_last_q ? '0 : ep_cnt_q + EPW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (desc_hs) begin
          ts_d       = desc_ts;
          samples_d  = desc_samples;
          ovr_d      = desc_ovr;
          sent_cnt_d = '0;
          rd_addr_d  = desc_start;
          ep_cnt_d   = '0;
          load       = 1'b1;
          load_val   = desc_ts[31:0];
          state_d    = ST_HDR0;
        end
      end
      ST_HDR0: begin
        if (out_hs) begin
          load     = 1'b1;
          load_val = {ovr_q, samples_q, ts_q[TW-1:32]};
          state_d  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (out_hs) begin
          load    = 1'b1;
          state_d = ST_HDR2;
        end
      end
      ST_HDR2: begin
        if (out_hs) begin
          load    = 1'b1;
          state_d = ST_HDR3;
        end
      end
      ST_HDR3: begin
        if (out_hs) begin
          state_d = ST_DATA_L;
          if (fifo_cnt_q != 2'd0) begin
            load     = 1'b1;
            load_val = head[31:0];
          end
        end
      end
      ST_DATA_L: begin
        if (out_hs) begin
          load       = 1'b1;
          load_val   = head[63:32];
          load_final = last_word;
          state_d    = ST_DATA_H;
        end else if (!out_valid_q && (fifo_cnt_q != 2'd0)) begin
          load     = 1'b1;
          load_val = head[31:0];
        end
      end
      ST_DATA_H: begin
        if (out_hs) begin
          pop        = 1'b1;
          rd_ptr_d   = ~rd_ptr_q;
          rd_addr_d  = rd_addr_q + AW'(1);
          sent_cnt_d = sent_cnt_q + SW'(1);
          if (last_word) begin
            final_hs = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_DATA_L;
            // The word behind the one just popped can go out without a bubble.
            if (fifo_cnt_q == 2'd2) begin
              load     = 1'b1;
              load_val = fifo_mem_q[~rd_ptr_q][31:0];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_val;
      out_last_d  = load_final || (ep_cnt_d == EPW'(EP_DWORDS - 1));
    end
  end

  always_comb begin
    ar_addr_d  = ar_addr_q;
    req_cnt_d  = req_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_mem_d = fifo_mem_q;
    if (desc_hs) begin
      ar_addr_d = desc_start;
      req_cnt_d = '0;
    end else if (ar_hs) begin
      ar_addr_d = ar_addr_q + AW'(1);
      req_cnt_d = req_cnt_q + RCW'(1);
    end
    if (r_acc) begin
      fifo_mem_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d             = ~wr_ptr_q;
    end
    outst_d    = outst_q + {1'b0, ar_hs} - {1'b0, r_acc};
    fifo_cnt_d = fifo_cnt_q + {1'b0, r_acc} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ep_cnt_q    <= '0;
      outst_q     <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ep_cnt_q    <= ep_cnt_d;
      outst_q     <= outst_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    ts_q       <= ts_d;
    samples_q  <= samples_d;
    ovr_q      <= ovr_d;
    sent_cnt_q <= sent_cnt_d;
    ar_addr_q  <= ar_addr_d;
    req_cnt_q  <= req_cnt_d;
    fifo_mem_q <= fifo_mem_d;
  end

`ifdef USBEPS_RX_FRAMER_STAT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [14:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    ovr_cnt_d = ovr_cnt_q;
    if (final_hs) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (ovr_q) ovr_cnt_d = ovr_cnt_q + 15'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      ovr_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign stat = {(state_q != ST_IDLE), ovr_cnt_q, pkt_cnt_q};
`else
  logic unused_stat;
  assign unused_stat = final_hs;
  assign stat        = 32'd0;
`endif

endmodule
